// File: rtl/fifo_rd_stream.sv
// Read-side adapter for the single-clock FIFO: issues ren, captures the
// registered dout a cycle later and serves it on a valid/ready stream.
module fifo_rd_stream #(
  parameter int dw = 32,
  parameter int cw = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fifo_empty,
  input  logic [dw-1:0] fifo_dout,
  output logic          fifo_ren,
  output logic [dw-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  input  logic          flush,
  output logic [cw-1:0] xfer_cnt
);

  // Stream handshake: a word transfers on every rising edge where
  // out_valid && out_ready; while out_valid=1 and out_ready=0 the word holds.

  logic [dw-1:0] buf_q [0:2];
  logic [1:0]    occ;
  logic          rd_pend;

  logic [dw-1:0] buf_n [0:2];
  logic [1:0]    occ_n;
  logic [1:0]    tail;
  logic          pop;

  // Issue only when the word can be guaranteed a slot when it lands.
  assign fifo_ren  = rst_n && !fifo_empty && !flush &&
                     (({1'b0, occ} + {2'b00, rd_pend}) < 3'd3);
  assign out_valid = (occ != 2'd0);
  assign out_data  = out_valid ? buf_q[0] : '0;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    for (int i = 0; i < 3; i++) buf_n[i] = buf_q[i];
    occ_n = occ;
    tail  = occ;
    if (pop) begin
      buf_n[0] = buf_q[1];
      buf_n[1] = buf_q[2];
      buf_n[2] = '0;
      tail     = occ - 2'd1;
      occ_n    = occ - 2'd1;
    end
    if (rd_pend) begin
      case (tail)
        2'd0:    buf_n[0] = fifo_dout;
        2'd1:    buf_n[1] = fifo_dout;
        2'd2:    buf_n[2] = fifo_dout;
        default: ;
      endcase
      if (tail != 2'd3) occ_n = occ_n + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) buf_q[i] <= '0;
      occ      <= 2'd0;
      rd_pend  <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      rd_pend <= fifo_ren;
      if (flush) begin
        // Buffered words and the word landing this edge are discarded.
        for (int i = 0; i < 3; i++) buf_q[i] <= '0;
        occ <= 2'd0;
      end else begin
        for (int i = 0; i < 3; i++) buf_q[i] <= buf_n[i];
        occ <= occ_n;
      end
      if (pop) xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(occ == 2'd3 && rd_pend && !pop && !flush));

endmodule
